// File: rtl/uart_rx_core_if.sv
// Receive-side bus between uart_rx_core and the UART bus peripheral.
//   rx_data   : received byte, valid while rx_valid=1
//   rx_valid  : holding register contains an unread byte
//   rx_ack    : read strobe, consumes the byte when rx_valid=1
//   err_clr   : clears frame_err and overrun
//   frame_err : sticky, a stop bit was sampled low
//   overrun   : sticky, a byte was lost to a full holding register
//   busy      : receiver FSM is not idle
// slave  = receiver side, master = peripheral side.
interface uart_rx_core_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       err_clr;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport slave (
        output rx_data, rx_valid, frame_err, overrun, busy,
        input  rx_ack, err_clr
    );

    modport master (
        input  rx_data, rx_valid, frame_err, overrun, busy,
        output rx_ack, err_clr
    );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with a one-entry holding register.
// Synchronises rxd, validates the start bit at its centre, samples each data
// bit at its centre (LSB first), checks the stop bit and hands the byte to the
// bus through a valid/ack handshake. Sticky framing-error and overrun flags.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   rxd   : asynchronous serial line, idle high
//   bus   : uart_rx_core_if.slave (rx_data/rx_valid/rx_ack/err_clr/
//           frame_err/overrun/busy)
// CLKS_PER_BIT must be at least 4.
module uart_rx_core #(
    parameter int unsigned CLKS_PER_BIT = 2604
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rxd,
    uart_rx_core_if.slave  bus
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          rx_meta;
    logic          rx_s;
    logic          rx_s_d;

    logic stop_hit;
    logic deliver;
    logic fe_set;
    logic ov_set;

    assign stop_hit = (state == STOP) && (cnt == LAST);
    assign deliver  = stop_hit && rx_s;
    assign fe_set   = stop_hit && !rx_s;
    // A byte is lost only if the old one is neither unread-free nor being read now.
    assign ov_set   = deliver && bus.rx_valid && !bus.rx_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta       <= 1'b1;
            rx_s          <= 1'b1;
            rx_s_d        <= 1'b1;
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            bus.rx_data   <= '0;
            bus.rx_valid  <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            rx_meta <= rxd;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;

            case (state)
                IDLE: begin
                    if (rx_s_d && !rx_s) begin
                        state    <= START;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        if (rx_s) begin
                            // Line back high at mid start bit: glitch.
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end else begin
                            state <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_HIGH: begin
                    // Held-low line: wait for high so IDLE needs a fresh edge.
                    if (rx_s) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase

            // Holding register: delivery takes priority, an ack in the same
            // cycle frees the slot for the new byte.
            if (deliver) begin
                if (!bus.rx_valid || bus.rx_ack) begin
                    bus.rx_data  <= shift;
                    bus.rx_valid <= 1'b1;
                end
            end else if (bus.rx_ack && bus.rx_valid) begin
                bus.rx_valid <= 1'b0;
            end

            // Sticky flags: a set event beats a coincident clear.
            if (fe_set) begin
                bus.frame_err <= 1'b1;
            end else if (bus.err_clr) begin
                bus.frame_err <= 1'b0;
            end

            if (ov_set) begin
                bus.overrun <= 1'b1;
            end else if (bus.err_clr) begin
                bus.overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 16 clocks per bit.
module tb_uart_rx_core;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic reset;
    logic rxd;
    logic rx_ack;
    logic err_clr;

    int n_checks = 0;
    int n_fail   = 0;
    logic seen_busy;

    uart_rx_core_if bus_if ();

    assign bus_if.rx_ack  = rx_ack;
    assign bus_if.err_clr = err_clr;

    uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .rxd   (rxd),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives n_cyc cycles of a 10-bit 8N1 frame (start, data LSB first, stop).
    // rx_ack is high during frame cycle ack_cyc (-1 for never); with the
    // 2-flop synchroniser the stop bit is sampled at the edge ending cycle 154.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input int ack_cyc, input int n_cyc, input logic end_level);
        logic [9:0] frame;
        frame = {stop_bit, data, 1'b0};
        @(posedge clk); #1;
        for (int cyc = 0; cyc < n_cyc; cyc++) begin
            rxd    = frame[cyc / CPB];
            rx_ack = (cyc == ack_cyc);
            @(posedge clk); #1;
        end
        rxd    = end_level;
        rx_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack;
        @(posedge clk); #1;
        rx_ack = 1'b1;
        @(posedge clk); #1;
        rx_ack = 1'b0;
    endtask

    task automatic pulse_clr;
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, required end of test");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b1;
        rxd     = 1'b1;
        rx_ack  = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset / idle line
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check8("idle_flags", {4'b0, bus_if.rx_valid, bus_if.frame_err, bus_if.overrun, bus_if.busy}, 8'h00);
        end
        check8("idle_data", bus_if.rx_data, 8'h00);

        // Basic frame 0xA5
        send_frame(8'hA5, 1'b1, -1, 10 * CPB, 1'b1);
        @(negedge clk);
        check1("a5_valid", bus_if.rx_valid, 1'b1);
        check8("a5_data", bus_if.rx_data, 8'hA5);
        check1("a5_fe", bus_if.frame_err, 1'b0);
        check1("a5_ov", bus_if.overrun, 1'b0);
        check1("a5_busy", bus_if.busy, 1'b0);
        pulse_ack();
        @(negedge clk);
        check1("a5_ack_valid", bus_if.rx_valid, 1'b0);
        check8("a5_ack_data", bus_if.rx_data, 8'hA5);

        // Glitch: 4 low cycles
        @(posedge clk); #1;
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        seen_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.busy) seen_busy = 1'b1;
        end
        check1("glitch_busy_seen", seen_busy, 1'b1);
        idle(30);
        @(negedge clk);
        check1("glitch_busy", bus_if.busy, 1'b0);
        check1("glitch_valid", bus_if.rx_valid, 1'b0);
        check1("glitch_fe", bus_if.frame_err, 1'b0);
        check1("glitch_ov", bus_if.overrun, 1'b0);

        // Bad stop bit followed by a 50 bit-time break
        send_frame(8'h3C, 1'b0, -1, 10 * CPB, 1'b0);
        idle(25 * CPB);
        @(negedge clk);
        check1("brk_fe", bus_if.frame_err, 1'b1);
        check1("brk_valid", bus_if.rx_valid, 1'b0);
        check1("brk_busy", bus_if.busy, 1'b1);
        pulse_clr();
        @(negedge clk);
        check1("brk_clr_fe", bus_if.frame_err, 1'b0);
        idle(25 * CPB);
        @(negedge clk);
        check1("brk_once_fe", bus_if.frame_err, 1'b0);
        check1("brk_wait_busy", bus_if.busy, 1'b1);
        @(posedge clk); #1;
        rxd = 1'b1;
        idle(10);
        @(negedge clk);
        check1("brk_end_busy", bus_if.busy, 1'b0);
        check1("brk_end_fe", bus_if.frame_err, 1'b0);
        check1("brk_end_valid", bus_if.rx_valid, 1'b0);

        // Bad stop then a good 0x81: frame_err stays sticky
        send_frame(8'h3C, 1'b0, -1, 10 * CPB, 1'b1);
        idle(10);
        @(negedge clk);
        check1("fe2_fe", bus_if.frame_err, 1'b1);
        check1("fe2_busy", bus_if.busy, 1'b0);
        send_frame(8'h81, 1'b1, -1, 10 * CPB, 1'b1);
        @(negedge clk);
        check8("x81_data", bus_if.rx_data, 8'h81);
        check1("x81_valid", bus_if.rx_valid, 1'b1);
        check1("x81_fe", bus_if.frame_err, 1'b1);
        pulse_clr();
        @(negedge clk);
        check1("x81_clr_fe", bus_if.frame_err, 1'b0);
        check1("x81_clr_valid", bus_if.rx_valid, 1'b1);
        pulse_ack();
        @(negedge clk);
        check1("x81_ack_valid", bus_if.rx_valid, 1'b0);

        // Overrun
        send_frame(8'h11, 1'b1, -1, 10 * CPB, 1'b1);
        @(negedge clk);
        check8("ov_first_data", bus_if.rx_data, 8'h11);
        check1("ov_first_ov", bus_if.overrun, 1'b0);
        send_frame(8'h22, 1'b1, -1, 10 * CPB, 1'b1);
        @(negedge clk);
        check8("ov_data", bus_if.rx_data, 8'h11);
        check1("ov_valid", bus_if.rx_valid, 1'b1);
        check1("ov_flag", bus_if.overrun, 1'b1);
        check1("ov_fe", bus_if.frame_err, 1'b0);
        pulse_clr();
        @(negedge clk);
        check1("ov_clr", bus_if.overrun, 1'b0);
        check8("ov_clr_data", bus_if.rx_data, 8'h11);
        // Ack in the delivery cycle: new byte replaces the old one
        send_frame(8'h22, 1'b1, 154, 10 * CPB, 1'b1);
        @(negedge clk);
        check8("ackdel_data", bus_if.rx_data, 8'h22);
        check1("ackdel_valid", bus_if.rx_valid, 1'b1);
        check1("ackdel_ov", bus_if.overrun, 1'b0);
        pulse_ack();
        @(negedge clk);
        check1("ackdel_drain", bus_if.rx_valid, 1'b0);

        // Reset in the middle of bit 3 of 0x5A
        send_frame(8'h5A, 1'b1, -1, 4 * CPB + CPB / 2, 1'b1);
        @(negedge clk);
        check1("rst_mid_busy", bus_if.busy, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        @(negedge clk);
        check1("rst_busy", bus_if.busy, 1'b0);
        check8("rst_data", bus_if.rx_data, 8'h00);
        idle(20);
        @(negedge clk);
        check8("rst_idle_flags", {4'b0, bus_if.rx_valid, bus_if.frame_err, bus_if.overrun, bus_if.busy}, 8'h00);
        send_frame(8'h7E, 1'b1, -1, 10 * CPB, 1'b1);
        @(negedge clk);
        check8("x7e_data", bus_if.rx_data, 8'h7E);
        check1("x7e_valid", bus_if.rx_valid, 1'b1);
        check1("x7e_fe", bus_if.frame_err, 1'b0);
        check1("x7e_ov", bus_if.overrun, 1'b0);
        check1("x7e_busy", bus_if.busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
